ram_arb_2x1_p1: RTL and testbench
=================================

# ram_arb_2x1_p1

Two-requester arbiter and sequencer for one port of the shared dual-port block RAM (registered read, 1-cycle latency). Interleaves two valid/ready request streams (e.g. instruction fetch and data load/store) onto a single RAM port with round-robin fairness. Routes read responses back to the issuing requester. Optionally zero-fills the RAM after reset before accepting traffic.

## Interface
- DEPTH, 512, RAM words; power of two
- WIDTH, 8, data bits per word
- DEPTH_BITS, $clog2(DEPTH), localparam; address width
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 presents a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_wr  in  1  1 = write, 0 = read
- req0_addr  in  DEPTH_BITS  word address
- req0_wdata  in  WIDTH  write data
- rsp0_valid  out  1  read data for requester 0 valid this cycle
- rsp0_rdata  out  WIDTH  read data
- req1_* / rsp1_*  same as requester 0
- ram_address  out  DEPTH_BITS  to RAM port address
- ram_wren  out  1  to RAM port write enable
- ram_data  out  WIDTH  to RAM port write data
- ram_q  in  WIDTH  from RAM port registered read data
- init_busy  out  1  zero-fill in progress; no requests accepted

## Operation
- States: INIT (zero-fill) and RUN. On reset, enter INIT when RAM_ARB_INIT_EN is defined, otherwise RUN.
- INIT:
  - Counter starts at 0. Each cycle drives ram_address = counter, ram_wren = 1, ram_data = 0.
  - Counter increments by 1 per cycle. After writing DEPTH-1, go to RUN.
  - Takes exactly DEPTH cycles. Both req*_ready = 0. init_busy = 1.
- RUN arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not granted at the last accepted transfer.
  - Priority pointer resets to favour requester 0. It updates only on an accepted transfer.
- Handshake:
  - reqN_ready is combinational from valid and the grant; at most one ready per cycle.
  - A transfer occurs at the edge where reqN_valid & reqN_ready.
  - Requester must hold valid and payload stable until accepted.
- RAM drive:
  - On transfer: ram_address = reqN_addr, ram_data = reqN_wdata, ram_wren = reqN_wr.
  - No transfer: ram_wren = 0, ram_address = 0, ram_data = 0.
- Responses:
  - An accepted read sets a 1-bit pending flag and owner ID.
  - Next cycle: rspN_valid = 1 for the owner only.
  - rsp0_rdata = rsp1_rdata = ram_q at all times; meaningful only when the matching rspN_valid = 1.
  - Writes produce no response.
  - Responses have no backpressure; the requester must sink them.

## Timing
- Reset values:
  - req*_ready = 0, rsp*_valid = 0, ram_wren = 0, ram_address = 0, ram_data = 0.
  - init_busy = 1 when INIT is compiled in, else 0.
  - Priority pointer = requester 0; pending flag clear.
  - rsp*_rdata follows ram_q and is undefined after reset.
- Read latency:
  - Request accepted at edge N; rspN_valid is high in the cycle after edge N and sampled at edge N+1.
  - Pipelined reads return in acceptance order.
- Throughput: one transfer per cycle total.
  - Both valid continuously: grants alternate 0,1,0,1…
- Back-to-back reads by different requesters: responses alternate with no gap.
- A write then a read to the same address in consecutive cycles returns the new data.
- Reset mid-INIT: counter restarts at 0.
- Reset mid-RUN: the pending response is dropped; rsp*_valid = 0 in the cycle after reset.
- Reset asserted: all requests are ignored in that cycle.
- The INIT→RUN transition happens on the edge that writes DEPTH-1. The first request can be accepted in the following cycle.

## Configuration
- RAM_ARB_INIT_EN defined:
  - INIT state and counter are compiled in.
  - After every reset, DEPTH zero-writes precede RUN, with init_busy high throughout.
- Not defined:
  - No INIT state or counter; init_busy is tied 0.
  - Requests may be accepted in the first cycle after reset is released.
  - RAM contents are not initialized.

## Test plan
- Zero-fill, init enabled, DEPTH=16: release reset → ram_wren=1 with addresses 0..15 and data 0 over 16 cycles; init_busy falls after the write of address 15. A read of address 7 then returns 0x00.
- Single read: req0 writes 0xA5 to address 3; one cycle later req0 reads address 3 → rsp0_valid=1 one cycle after acceptance, rsp0_rdata=0xA5, rsp1_valid=0.
- Contention: both valid reading addresses 1 and 2 (holding 0x11 and 0x22) for 4 cycles → grants 0,1,0,1. rsp valids alternate with rdata 0x11,0x22,0x11,0x22.
- Fairness persistence: req1 accepted alone, then both valid → req0 granted first.
- Write then read: req1 writes 0x5C to address 9, then immediately req0 reads address 9 → rsp0_rdata=0x5C.
- Reset mid-operation: assert reset in the cycle after a read is accepted → no rsp*_valid afterward. With init enabled, ram_address restarts at 0 after reset is released.

Source files
------------

// File: rtl/ram_arb_2x1_p1.sv
// ram_arb_2x1_p1: two-requester round-robin arbiter for one port of a block RAM with
// registered (1-cycle) read data. Read responses are routed back to the issuing requester.
// Optional zero-fill after reset is enabled by defining RAM_ARB_INIT_EN.
module ram_arb_2x1_p1 #(
    parameter  int unsigned DEPTH      = 512,
    parameter  int unsigned WIDTH      = 8,
    localparam int unsigned DEPTH_BITS = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_wr,
    input  logic [DEPTH_BITS-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_wdata,
    output logic                  rsp0_valid,
    output logic [WIDTH-1:0]      rsp0_rdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_wr,
    input  logic [DEPTH_BITS-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_wdata,
    output logic                  rsp1_valid,
    output logic [WIDTH-1:0]      rsp1_rdata,

    output logic [DEPTH_BITS-1:0] ram_address,
    output logic                  ram_wren,
    output logic [WIDTH-1:0]      ram_data,
    input  logic [WIDTH-1:0]      ram_q,

    output logic                  init_busy
);

    // High when requests may be granted this cycle.
    logic run_en;
    // High while the zero-fill sequencer owns the RAM port.
    logic init_drive;
    logic [DEPTH_BITS-1:0] init_addr;

`ifdef RAM_ARB_INIT_EN
    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_BITS-1:0] init_cnt_q, init_cnt_d;

    // State register: every reset restarts the zero-fill from address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: step the fill counter; leave INIT on the edge that writes the last word.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == StInit) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == DEPTH_BITS'(DEPTH - 1)) begin
                state_d    = StRun;
                init_cnt_d = '0;
            end
        end
    end

    // FSM outputs; reset suppresses all RAM activity in its own cycle.
    always_comb begin
        init_busy  = reset | (state_q == StInit);
        init_drive = ~reset & (state_q == StInit);
        run_en     = ~reset & (state_q == StRun);
        init_addr  = init_cnt_q;
    end
`else
    // No zero-fill: requests are eligible whenever reset is low.
    always_comb begin
        init_busy  = 1'b0;
        init_drive = 1'b0;
        run_en     = ~reset;
        init_addr  = '0;
    end
`endif

    // Requester granted at the last accepted transfer; resets to 1 so requester 0 wins first.
    logic last_grant_q;
    logic gnt0, gnt1;
    logic rsp_pending_q;
    logic rsp_owner_q;

    // Round-robin grant; on contention the requester not served last time wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (run_en) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    // Ready is the grant itself, so at most one is high and it implies valid.
    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
    end

    // RAM port mux: fill sequencer, granted requester, or idle zeros.
    always_comb begin
        ram_address = '0;
        ram_wren    = 1'b0;
        ram_data    = '0;
        if (init_drive) begin
            ram_address = init_addr;
            ram_wren    = 1'b1;
        end else if (gnt0) begin
            ram_address = req0_addr;
            ram_wren    = req0_wr;
            ram_data    = req0_wdata;
        end else if (gnt1) begin
            ram_address = req1_addr;
            ram_wren    = req1_wr;
            ram_data    = req1_wdata;
        end
    end

    // Priority pointer moves only on an accepted transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            last_grant_q <= gnt1;
        end
    end

    // Track the read issued this cycle; its data appears on ram_q next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= 1'b0;
        end else begin
            rsp_pending_q <= (gnt0 & ~req0_wr) | (gnt1 & ~req1_wr);
            rsp_owner_q   <= gnt1;
        end
    end

    // Response routing; read data is shared and qualified by the per-requester valid.
    always_comb begin
        rsp0_valid = rsp_pending_q & ~rsp_owner_q;
        rsp1_valid = rsp_pending_q & rsp_owner_q;
        rsp0_rdata = ram_q;
        rsp1_rdata = ram_q;
    end

endmodule

// File: tb/tb_ram_arb_2x1_p1.sv
// Testbench for ram_arb_2x1_p1 (DEPTH=16, WIDTH=8) with a behavioural RAM and a
// transaction-level reference model. Zero-fill checks run when RAM_ARB_INIT_EN is defined.
module tb_ram_arb_2x1_p1;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 4;
`ifdef RAM_ARB_INIT_EN
    localparam bit HAS_INIT = 1'b1;
`else
    localparam bit HAS_INIT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic             v     [2];
    logic             wr    [2];
    logic [AW-1:0]    addr  [2];
    logic [WIDTH-1:0] wdata [2];

    logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0]    ram_address;
    logic             ram_wren;
    logic [WIDTH-1:0] ram_data;
    logic [WIDTH-1:0] ram_q = '0;
    logic             init_busy;

    logic [WIDTH-1:0] mem [DEPTH] = '{default: 8'h00};

    ram_arb_2x1_p1 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (v[0]),
        .req0_ready  (req0_ready),
        .req0_wr     (wr[0]),
        .req0_addr   (addr[0]),
        .req0_wdata  (wdata[0]),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rdata  (rsp0_rdata),
        .req1_valid  (v[1]),
        .req1_ready  (req1_ready),
        .req1_wr     (wr[1]),
        .req1_addr   (addr[1]),
        .req1_wdata  (wdata[1]),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rdata  (rsp1_rdata),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_q       (ram_q),
        .init_busy   (init_busy)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM with registered read.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int               last_g = 1;
    bit               pend   = 1'b0;
    int               pend_owner = 0;
    logic [WIDTH-1:0] pend_data = '0;
    logic [WIDTH-1:0] shadow [DEPTH] = '{default: 8'h00};
    bit               acc [2] = '{1'b0, 1'b0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit val, input bit w, input int a, input int d);
        v[i]     = val;
        wr[i]    = w;
        addr[i]  = AW'(a);
        wdata[i] = WIDTH'(d);
    endtask

    // One RUN-mode (or reset) cycle: compare at negedge, advance model after posedge.
    task automatic step();
        int g;
        @(negedge clock);
        g = -1;
        if (!reset) begin
            if (v[0] && v[1]) g = (last_g == 1) ? 0 : 1;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        check_eq("req0_ready", req0_ready, g == 0);
        check_eq("req1_ready", req1_ready, g == 1);
        check_eq("ram_wren", ram_wren, (g >= 0) ? wr[g] : 1'b0);
        check_eq("ram_address", ram_address, (g >= 0) ? addr[g] : '0);
        check_eq("ram_data", ram_data, (g >= 0) ? wdata[g] : '0);
        check_eq("init_busy", init_busy, reset ? HAS_INIT : 1'b0);
        if (!reset) begin
            check_eq("rsp0_valid", rsp0_valid, pend && pend_owner == 0);
            check_eq("rsp1_valid", rsp1_valid, pend && pend_owner == 1);
            if (pend && pend_owner == 0) check_eq("rsp0_rdata", rsp0_rdata, pend_data);
            if (pend && pend_owner == 1) check_eq("rsp1_rdata", rsp1_rdata, pend_data);
        end
        @(posedge clock);
        pend = 1'b0;
        if (reset) begin
            last_g = 1;
        end else if (g >= 0) begin
            last_g = g;
            if (wr[g]) begin
                shadow[addr[g]] = wdata[g];
            end else begin
                pend       = 1'b1;
                pend_owner = g;
                pend_data  = shadow[addr[g]];
            end
        end
        acc[0] = (g == 0);
        acc[1] = (g == 1);
        #1;
    endtask

    // Zero-fill phase: DEPTH writes of 0 at ascending addresses, requests ignored.
    task automatic run_init();
        for (int k = 0; k < DEPTH; k++) begin
            set_req(0, 1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom);
            set_req(1, 1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom);
            @(negedge clock);
            check_eq("init_busy", init_busy, 1'b1);
            check_eq("init_wren", ram_wren, 1'b1);
            check_eq("init_addr", ram_address, k);
            check_eq("init_data", ram_data, 8'h00);
            check_eq("init_ready0", req0_ready, 1'b0);
            check_eq("init_ready1", req1_ready, 1'b0);
            check_eq("init_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
            @(posedge clock);
            shadow[k] = 8'h00;
            #1;
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
    endtask

    task automatic idle();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        #1;
        // Reset held with traffic present: nothing may be accepted.
        reset = 1'b1;
        set_req(0, 1, 1, 5, 8'hEE);
        set_req(1, 1, 0, 6, 0);
        step();
        step();
        check_eq("rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        reset = 1'b0;
        if (HAS_INIT) run_init();

        // Read of a zero-filled word.
        set_req(0, 1, 0, 7, 0);
        step();
        idle();

        // Single write then read by requester 0.
        set_req(0, 1, 1, 3, 8'hA5);
        step();
        set_req(0, 1, 0, 3, 0);
        step();
        idle();

        // Contention: grants alternate starting from requester 0.
        set_req(0, 1, 1, 1, 8'h11);
        step();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 1, 2, 8'h22);
        step();
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("contend_grant", {acc[1], acc[0]}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle();

        // Fairness persists across idle cycles.
        set_req(1, 1, 0, 2, 0);
        step();
        idle();
        set_req(0, 1, 0, 1, 0);
        set_req(1, 1, 0, 2, 0);
        step();
        check_eq("fair_grant0", acc[0], 1'b1);
        idle();

        // Write by requester 1, immediate read by requester 0.
        set_req(1, 1, 1, 9, 8'h5C);
        step();
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 0, 9, 0);
        step();
        idle();

        // Reset in the cycle after a read is accepted.
        set_req(0, 1, 0, 3, 0);
        step();
        reset = 1'b1;
        set_req(0, 1, 0, 3, 0);
        set_req(1, 1, 1, 4, 8'h77);
        step();
        reset = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        if (HAS_INIT) run_init();
        step();
        check_eq("post_rst_rsp", {rsp1_valid, rsp0_valid}, 2'b00);

        // Randomized traffic; a pending request is held until accepted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] || acc[i]) begin
                    set_req(i, ($urandom % 4) != 0, 1'($urandom),
                            $urandom_range(0, DEPTH - 1), $urandom);
                end
            end
            step();
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
